// File: rtl/sign_magnitude_accumulator.sv
// sign_magnitude_accumulator
//   Streaming accumulator for sign-magnitude terms. A packet of terms comes in
//   over a valid/ready port. One sign-magnitude sum per packet goes out over a
//   valid/ready port, together with a sticky overflow flag and a term count.
//   The accumulator is two's complement internally. SATURATE=1 clamps the sum
//   to +/-(2^WIDTH-1) after every add. SATURATE=0 keeps an exact sum in a guard
//   range and reports overflow at the end of the packet.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_valid      input term valid
//   o_ready      block accepts a term this cycle
//   i_sign       term sign (1 = negative)
//   i_magnitude  term magnitude [WIDTH]
//   i_last       term is the last of its packet
//   o_valid      result valid
//   i_ready      downstream accepts the result
//   o_sign       result sign (0 whenever o_magnitude == 0)
//   o_magnitude  result magnitude [WIDTH]
//   o_overflow   sticky overflow for the packet
//   o_count      terms in the packet, saturating [COUNT_WIDTH]
//   o_dbg_state  current FSM state (0 = ACCUM, 1 = OUT)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data stable while valid is high and ready is
// low. o_ready depends only on state and i_rst. o_valid depends only on state.
// Neither port ever waits on the other port's valid.

module sign_magnitude_accumulator #(
  parameter int WIDTH       = 16,
  parameter int GUARD       = 4,
  parameter int SATURATE    = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_sign,
  input  logic [WIDTH-1:0]       i_magnitude,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_sign,
  output logic [WIDTH-1:0]       o_magnitude,
  output logic                   o_overflow,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic [0:0]             o_dbg_state
);

  // Saturating mode needs one bit for the sign. It needs one more bit to hold
  // the sum of two in-range values before the clamp is applied.
  localparam int ACC_W = (SATURATE != 0) ? WIDTH + 2 : WIDTH + 1 + GUARD;

  localparam logic [ACC_W-1:0] MAX_EXT = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_OUT   = 1'b1;

  logic [0:0]             state;
  logic [ACC_W-1:0]       acc;
  logic                   sticky;
  logic [COUNT_WIDTH-1:0] cnt;

  logic [ACC_W-1:0]       mag_ext;
  logic [ACC_W-1:0]       term;
  logic [ACC_W:0]         sum_wide;
  logic [ACC_W-1:0]       sum_trunc;
  logic [ACC_W-1:0]       sum_abs;
  logic [ACC_W-1:0]       neg_max;
  logic                   wrap_ovf;
  logic                   sum_big;
  logic [ACC_W-1:0]       acc_next;
  logic                   sticky_next;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic [ACC_W-1:0]       res_abs;
  logic [WIDTH-1:0]       res_mag;
  logic                   res_ovf;
  logic                   res_sign;
  logic                   accept;

  assign o_ready     = (state == ST_ACCUM) && !i_rst;
  assign o_valid     = (state == ST_OUT);
  assign o_dbg_state = state;
  assign accept      = i_valid && o_ready;

  always_comb begin
    mag_ext  = {{(ACC_W-WIDTH){1'b0}}, i_magnitude};
    // Negating a zero magnitude gives zero, so -0 adds the same value as +0.
    term     = i_sign ? (~mag_ext + 1'b1) : mag_ext;
    // Sign-extend by one bit so that two's-complement overflow of the
    // accumulator shows up as disagreement between the top two bits.
    sum_wide  = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    sum_trunc = sum_wide[ACC_W-1:0];
    wrap_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum_abs   = sum_trunc[ACC_W-1] ? (~sum_trunc + 1'b1) : sum_trunc;
    sum_big   = (sum_abs > MAX_EXT);
    neg_max   = ~MAX_EXT + 1'b1;

    if (SATURATE != 0) begin
      if (sum_big) begin
        acc_next = sum_trunc[ACC_W-1] ? neg_max : MAX_EXT;
      end else begin
        acc_next = sum_trunc;
      end
      sticky_next = sticky | sum_big;
    end else begin
      acc_next    = sum_trunc;
      sticky_next = sticky | wrap_ovf;
    end

    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Result fields are taken from the sum that includes the current term.
    res_abs  = acc_next[ACC_W-1] ? (~acc_next + 1'b1) : acc_next;
    res_mag  = res_abs[WIDTH-1:0];
    res_ovf  = sticky_next | (res_abs > MAX_EXT);
    // A wrapped sum can be negative while its low WIDTH bits are zero. The
    // sign is suppressed in that case so that a zero result never reads as -0.
    res_sign = acc_next[ACC_W-1] && (res_mag != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_ACCUM;
      acc         <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      o_sign      <= 1'b0;
      o_magnitude <= '0;
      o_overflow  <= 1'b0;
      o_count     <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc    <= acc_next;
            sticky <= sticky_next;
            cnt    <= cnt_next;
            if (i_last) begin
              state       <= ST_OUT;
              o_sign      <= res_sign;
              o_magnitude <= res_mag;
              o_overflow  <= res_ovf;
              o_count     <= cnt_next;
            end
          end
        end
        ST_OUT: begin
          // The data outputs keep their values after the handoff. Only the
          // packet state is cleared for the next packet.
          if (i_ready) begin
            state  <= ST_ACCUM;
            acc    <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_magnitude_accumulator.sv
// Bench for sign_magnitude_accumulator (WIDTH=8). Three instances share one
// input stream: a saturating one, an exact guard-range one (GUARD=4) and a
// saturating one with a 2-bit counter.
module tb_sign_magnitude_accumulator;

  // ---------------- clock / reset / signals ----------------
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_sign = 1'b0;
  logic [7:0] i_magnitude = 8'd0;
  logic       i_last = 1'b0;
  logic       i_ready = 1'b1;

  logic       r0, v0, s0, ov0;
  logic [7:0] m0, c0;
  logic [0:0] st0;
  logic       r1, v1, s1, ov1;
  logic [7:0] m1, c1;
  logic [0:0] st1;
  logic       r2, v2, s2, ov2;
  logic [7:0] m2;
  logic [1:0] c2;
  logic [0:0] st2;

  always #5 i_clk = ~i_clk;

  sign_magnitude_accumulator #(.WIDTH(8), .GUARD(4), .SATURATE(1), .COUNT_WIDTH(8)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(r0),
    .i_sign(i_sign), .i_magnitude(i_magnitude), .i_last(i_last),
    .o_valid(v0), .i_ready(i_ready), .o_sign(s0), .o_magnitude(m0),
    .o_overflow(ov0), .o_count(c0), .o_dbg_state(st0)
  );

  sign_magnitude_accumulator #(.WIDTH(8), .GUARD(4), .SATURATE(0), .COUNT_WIDTH(8)) dut_wrap (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(r1),
    .i_sign(i_sign), .i_magnitude(i_magnitude), .i_last(i_last),
    .o_valid(v1), .i_ready(i_ready), .o_sign(s1), .o_magnitude(m1),
    .o_overflow(ov1), .o_count(c1), .o_dbg_state(st1)
  );

  sign_magnitude_accumulator #(.WIDTH(8), .GUARD(4), .SATURATE(1), .COUNT_WIDTH(2)) dut_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(r2),
    .i_sign(i_sign), .i_magnitude(i_magnitude), .i_last(i_last),
    .o_valid(v2), .i_ready(i_ready), .o_sign(s2), .o_magnitude(m2),
    .o_overflow(ov2), .o_count(c2), .o_dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  // {sign, magnitude[7:0], overflow, count[7:0]}
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [17:0] exp_q2[$];

  int sat_acc, sat_sticky, wrap_acc, wrap_sticky, n_terms;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sat_acc = 0; sat_sticky = 0; wrap_acc = 0; wrap_sticky = 0; n_terms = 0;
  endtask

  // Reference arithmetic on plain integers: saturating range +/-255,
  // guard range [-4096, 4095] with wraparound.
  task automatic model_add(input logic s, input int mag);
    int t;
    t = s ? -mag : mag;
    n_terms++;
    sat_acc = sat_acc + t;
    if (sat_acc > 255) begin
      sat_acc = 255; sat_sticky = 1;
    end else if (sat_acc < -255) begin
      sat_acc = -255; sat_sticky = 1;
    end
    wrap_acc = wrap_acc + t;
    if (wrap_acc > 4095 || wrap_acc < -4096) begin
      wrap_sticky = 1;
      wrap_acc = ((wrap_acc + 4096 + 8192) % 8192) - 4096;
    end
  endtask

  function automatic logic [17:0] pack_res(input int acc, input int sticky, input int cnt);
    int a;
    int mag;
    logic s;
    logic ovf;
    a   = (acc < 0) ? -acc : acc;
    mag = a % 256;
    s   = (acc < 0) && (mag != 0);
    ovf = (sticky != 0) || (a > 255);
    return {s, mag[7:0], ovf, cnt[7:0]};
  endfunction

  task automatic model_push();
    exp_q0.push_back(pack_res(sat_acc, sat_sticky, (n_terms > 255) ? 255 : n_terms));
    exp_q1.push_back(pack_res(wrap_acc, wrap_sticky, (n_terms > 255) ? 255 : n_terms));
    exp_q2.push_back(pack_res(sat_acc, sat_sticky, (n_terms > 3) ? 3 : n_terms));
    model_clear();
  endtask

  // Results are popped when a result handshake is about to happen.
  always @(negedge i_clk) begin
    if (!i_rst && i_ready === 1'b1) begin
      if (v0 === 1'b1) begin
        if (exp_q0.size() == 0) chk("unexpected_res_sat", 1, 0);
        else chk("res_sat", {14'd0, s0, m0, ov0, c0}, {14'd0, exp_q0.pop_front()});
      end
      if (v1 === 1'b1) begin
        if (exp_q1.size() == 0) chk("unexpected_res_wrap", 1, 0);
        else chk("res_wrap", {14'd0, s1, m1, ov1, c1}, {14'd0, exp_q1.pop_front()});
      end
      if (v2 === 1'b1) begin
        if (exp_q2.size() == 0) chk("unexpected_res_cnt", 1, 0);
        else chk("res_cnt", {14'd0, s2, m2, ov2, 6'd0, c2}, {14'd0, exp_q2.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge. Outputs are sampled on
  // the falling edge.
  task automatic send_term(input logic s, input int mag, input logic last);
    logic ok;
    logic done;
    done = 1'b0;
    i_valid = 1'b1; i_sign = s; i_magnitude = mag[7:0]; i_last = last;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge i_clk);
      ok = r0;
      @(posedge i_clk);
      #1;
      if (ok) begin
        done = 1'b1;
        model_add(s, mag);
        if (last) model_push();
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    i_valid = 1'b0; i_last = 1'b0;
    if (last && done) begin
      @(negedge i_clk);
      chk("latency_o_valid", {31'd0, v0}, 1);
      @(posedge i_clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_clear();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("init_ready", {31'd0, r0}, 0);
    chk("init_valid", {31'd0, v0}, 0);
    chk("init_mag",   {24'd0, m0}, 0);
    chk("init_cnt",   {24'd0, c0}, 0);
    chk("init_ovf",   {31'd0, ov0}, 0);
    chk("init_sign",  {31'd0, s0}, 0);
    @(posedge i_clk); #1; i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ready", {31'd0, r0}, 1);
    chk("post_rst_state", {31'd0, st0}, 0);
    @(posedge i_clk); #1;

    // Basic mixed-sign sum: 75
    send_term(0, 100, 0); send_term(1, 30, 0); send_term(0, 5, 1);
    // Clamp to 255 after term 2 when saturating; exact 150 in guard range
    send_term(0, 200, 0); send_term(0, 100, 0); send_term(1, 150, 1);
    // -0 and cancellation both give +0
    send_term(1, 0, 1);
    send_term(1, 5, 0); send_term(0, 5, 1);
    // Negative saturation / negative guard-range sum
    send_term(1, 200, 0); send_term(1, 200, 1);

    // Backpressure: the result is held, and a term offered meanwhile is not consumed
    i_ready = 1'b0;
    send_term(0, 10, 0); send_term(0, 20, 1);
    i_valid = 1'b1; i_sign = 1'b0; i_magnitude = 8'd77; i_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("hold_valid", {31'd0, v0}, 1);
      chk("hold_ready", {31'd0, r0}, 0);
      chk("hold_mag",   {24'd0, m0}, 30);
      chk("hold_cnt",   {24'd0, c0}, 2);
      chk("hold_state", {31'd0, st0}, 1);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("release_valid", {31'd0, v0}, 0);
    @(posedge i_clk); #1;
    send_term(0, 3, 1);

    // Reset mid-packet discards the partial sum and clears the outputs
    send_term(0, 50, 0); send_term(0, 60, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_ready_low", {31'd0, r0}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_clear();
    @(negedge i_clk);
    chk("rst_mag",   {24'd0, m0}, 0);
    chk("rst_cnt",   {24'd0, c0}, 0);
    chk("rst_valid", {31'd0, v0}, 0);
    chk("rst_ready", {31'd0, r0}, 1);
    @(posedge i_clk); #1;
    send_term(0, 7, 1);

    // Count saturation on the 2-bit instance
    for (int k = 0; k < 5; k++) send_term(0, 1, (k == 4));

    // Guard-range wrap: 20 x 255 = 5100 exceeds 4095
    for (int k = 0; k < 20; k++) send_term(0, 255, (k == 19));

    // Random packets
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send_term(1'($urandom_range(0, 1)), $urandom_range(0, 255), (k == len - 1));
    end

    // Drain and report
    for (int k = 0; k < 30 && (exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0; k++)
      @(posedge i_clk);
    chk("drain_q_sat",  exp_q0.size(), 0);
    chk("drain_q_wrap", exp_q1.size(), 0);
    chk("drain_q_cnt",  exp_q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
